// File: rtl/mem_arbiter_rr.sv
// Round-robin memory-port arbiter: master 0 has priority and may preempt the others; masters 1..N-1 share the port round-robin.
// Define ARB_STARVE_MON_EN to build per-master wait counters that drive the sticky starve_err_o flag.
module mem_arbiter_rr #(
    parameter int N_MASTERS    = 3,
    parameter int MAX_HOLD     = 2,
    parameter int CNT_W        = 16,
    parameter int STARVE_LIMIT = 16,
    localparam int IDX_W       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [N_MASTERS-1:0] done_i,
    output logic [N_MASTERS-1:0] grant_o,
    output logic [IDX_W-1:0]     gnt_idx_o,
    output logic                 busy_o,
    output logic                 preempt_o,
    output logic [CNT_W-1:0]     nb_interrupts_o,
    output logic                 starve_err_o
);

    localparam int HOLD_W = $clog2(MAX_HOLD);

    if (N_MASTERS < 2 || N_MASTERS > 8) begin : gBadMasters
        $error("mem_arbiter_rr: N_MASTERS must be 2..8");
    end
    if (MAX_HOLD < 2) begin : gBadHold
        $error("mem_arbiter_rr: MAX_HOLD must be at least 2");
    end
    if (STARVE_LIMIT < 1) begin : gBadLimit
        $error("mem_arbiter_rr: STARVE_LIMIT must be at least 1");
    end

    typedef enum logic {IDLE, GRANT} state_e;

    state_e                 state_q, state_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   pgrant_q, pgrant_d;
    logic                   preempt_q, preempt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   holderDone;
    logic                   atLimit;
    logic                   bounded;
    logic                   releaseEv;
    logic                   preemptEv;
    logic                   arbitrate;
    logic [N_MASTERS-1:0]   eligible;
    logic                   winValid;
    logic [IDX_W-1:0]       winIdx;
    logic [IDX_W:0]         rrSum;

    // Only the granted master's done bit matters, so masking by the one-hot grant is enough.
    assign holderDone = (state_q == GRANT) && |(done_i & grant_q);
    assign atLimit    = (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign bounded    = (idx_q != '0) || pgrant_q;
    assign releaseEv  = (state_q == GRANT) && (holderDone || (bounded && atLimit));
    assign preemptEv  = (state_q == GRANT) && (idx_q != '0) && !holderDone && req_i[0] && !atLimit;
    assign arbitrate  = (state_q == IDLE) || releaseEv;
    assign eligible   = req_i & ~(releaseEv ? grant_q : '0);

    always_comb begin
        winValid = 1'b0;
        winIdx   = '0;
        rrSum    = '0;
        if (eligible[0]) begin
            winValid = 1'b1;
        end else begin
            for (int off = 0; off < N_MASTERS - 1; off++) begin
                rrSum = {1'b0, rr_q} + (IDX_W + 1)'(off);
                if (rrSum > (IDX_W + 1)'(N_MASTERS - 1)) begin
                    rrSum = rrSum - (IDX_W + 1)'(N_MASTERS - 1);
                end
                if (!winValid && eligible[rrSum[IDX_W-1:0]]) begin
                    winValid = 1'b1;
                    winIdx   = rrSum[IDX_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            rr_q      <= IDX_W'(1);
            hold_q    <= '0;
            pgrant_q  <= 1'b0;
            preempt_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            rr_q      <= rr_d;
            hold_q    <= hold_d;
            pgrant_q  <= pgrant_d;
            preempt_q <= preempt_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = winValid ? GRANT : IDLE;
            GRANT: begin
                if (preemptEv) begin
                    state_d = GRANT;
                end else if (releaseEv) begin
                    state_d = winValid ? GRANT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d   = grant_q;
        idx_d     = idx_q;
        rr_d      = rr_q;
        hold_d    = hold_q;
        pgrant_d  = pgrant_q;
        preempt_d = 1'b0;
        cnt_d     = cnt_q;
        if (preemptEv) begin
            grant_d   = N_MASTERS'(1);
            idx_d     = '0;
            hold_d    = '0;
            pgrant_d  = 1'b1;
            preempt_d = 1'b1;
            cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (arbitrate) begin
            hold_d   = '0;
            pgrant_d = 1'b0;
            if (winValid) begin
                grant_d = N_MASTERS'(1) << winIdx;
                idx_d   = winIdx;
                if (winIdx != '0) begin
                    rr_d = (winIdx == IDX_W'(N_MASTERS - 1)) ? IDX_W'(1) : winIdx + IDX_W'(1);
                end
            end else begin
                grant_d = '0;
                idx_d   = '0;
            end
        end else if (!atLimit) begin
            // An unbounded master-0 grant parks its counter at the limit instead of wrapping.
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    assign grant_o         = grant_q;
    assign gnt_idx_o       = idx_q;
    assign busy_o          = (state_q == GRANT);
    assign preempt_o       = preempt_q;
    assign nb_interrupts_o = cnt_q;

`ifdef ARB_STARVE_MON_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [WAIT_W-1:0] wait_q [N_MASTERS];
    logic [WAIT_W-1:0] wait_d [N_MASTERS];
    logic              starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (wait_q[i] == WAIT_W'(STARVE_LIMIT)) begin
                starve_d = 1'b1;
            end
            if (req_i[i] && !grant_q[i]) begin
                wait_d[i] = (wait_q[i] == WAIT_W'(STARVE_LIMIT)) ? wait_q[i] : wait_q[i] + WAIT_W'(1);
            end else begin
                wait_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= 1'b0;
            for (int i = 0; i < N_MASTERS; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            starve_q <= starve_d;
            for (int i = 0; i < N_MASTERS; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    assign starve_err_o = starve_q;
`else
    assign starve_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr: directed scenarios plus random traffic against a transaction-level model.
// A second instance with a 2-bit interruption counter checks counter saturation.
module tb_mem_arbiter_rr;

    localparam int N     = 3;
    localparam int MH    = 2;
    localparam int LIMIT = 16;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req   = '0;
    logic [N-1:0] done  = '0;

    logic [N-1:0] grant, grant2;
    logic [1:0]   idx, idx2;
    logic         busy, busy2, pre, pre2, starve, starve2;
    logic [15:0]  nb;
    logic [1:0]   nb2;

    mem_arbiter_rr #(.N_MASTERS(N), .MAX_HOLD(MH), .CNT_W(16), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .req_i(req), .done_i(done),
        .grant_o(grant), .gnt_idx_o(idx), .busy_o(busy), .preempt_o(pre),
        .nb_interrupts_o(nb), .starve_err_o(starve)
    );

    mem_arbiter_rr #(.N_MASTERS(N), .MAX_HOLD(MH), .CNT_W(2), .STARVE_LIMIT(LIMIT)) dutSat (
        .clk(clk), .reset(reset), .req_i(req), .done_i(done),
        .grant_o(grant2), .gnt_idx_o(idx2), .busy_o(busy2), .preempt_o(pre2),
        .nb_interrupts_o(nb2), .starve_err_o(starve2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        logic [1:0]   idx;
        logic         busy;
        logic         preempt;
        logic [15:0]  nb;
        logic [1:0]   nbSat;
        logic         starve;
    } expect_t;

    expect_t expQ[$];
    int vectors     = 0;
    int miscompares = 0;

    // Transaction-level view: who owns the port, for how many cycles, and why.
    int holder     = -1;
    int held       = 0;
    bit preGrant   = 1'b0;
    int rrPtr      = 1;
    int interrupts = 0;
    bit pulse      = 1'b0;
    int waits[N];
    bit starveFlag = 1'b0;

    function automatic bit bitOf(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    function automatic void modelReset();
        holder     = -1;
        held       = 0;
        preGrant   = 1'b0;
        rrPtr      = 1;
        interrupts = 0;
        pulse      = 1'b0;
        starveFlag = 1'b0;
        for (int i = 0; i < N; i++) waits[i] = 0;
    endfunction

    function automatic void modelStep(input logic [N-1:0] rq, input logic [N-1:0] dn);
        int  releaser;
        int  winner;
        int  m;
        bit  releasing;
        bit  takeover;
        for (int i = 0; i < N; i++) if (waits[i] >= LIMIT) starveFlag = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (bitOf(rq, i) && holder != i) waits[i] = waits[i] + 1;
            else waits[i] = 0;
        end
        releaser  = -1;
        releasing = 1'b0;
        takeover  = 1'b0;
        pulse     = 1'b0;
        if (holder >= 0) begin
            releasing = bitOf(dn, holder) || ((holder != 0 || preGrant) && held >= MH);
            takeover  = !releasing && holder != 0 && bitOf(rq, 0);
            if (releasing) releaser = holder;
        end
        if (takeover) begin
            holder     = 0;
            held       = 1;
            preGrant   = 1'b1;
            pulse      = 1'b1;
            interrupts = interrupts + 1;
        end else if (holder < 0 || releasing) begin
            winner = -1;
            if (bitOf(rq, 0) && releaser != 0) begin
                winner = 0;
            end else begin
                for (int s = 0; s < N - 1; s++) begin
                    m = 1 + (rrPtr - 1 + s) % (N - 1);
                    if (winner < 0 && bitOf(rq, m) && m != releaser) winner = m;
                end
            end
            holder   = winner;
            held     = (winner >= 0) ? 1 : 0;
            preGrant = 1'b0;
            if (winner > 0) rrPtr = winner % (N - 1) + 1;
        end else begin
            held = held + 1;
        end
    endfunction

    function automatic expect_t modelOutputs();
        expect_t e;
        e.grant   = (holder >= 0) ? (N'(1) << holder) : '0;
        e.idx     = (holder >= 0) ? 2'(holder) : 2'd0;
        e.busy    = (holder >= 0);
        e.preempt = pulse;
        e.nb      = (interrupts > 65535) ? 16'hFFFF : 16'(interrupts);
        e.nbSat   = (interrupts > 3) ? 2'd3 : 2'(interrupts);
`ifdef ARB_STARVE_MON_EN
        e.starve  = starveFlag;
`else
        e.starve  = 1'b0;
`endif
        return e;
    endfunction

    task automatic checkOutput(input expect_t e);
        vectors++;
        if (grant !== e.grant || idx !== e.idx || busy !== e.busy || pre !== e.preempt ||
            nb !== e.nb || starve !== e.starve || nb2 !== e.nbSat || grant2 !== e.grant ||
            idx2 !== e.idx || busy2 !== e.busy || pre2 !== e.preempt || starve2 !== e.starve) begin
            miscompares++;
            $display("[TB] FAIL vec%0d t=%0t got grant=%b idx=%0d busy=%b pre=%b nb=%0d starve=%b | sat grant=%b idx=%0d busy=%b pre=%b nb=%0d starve=%b ; want grant=%b idx=%0d busy=%b pre=%b nb=%0d nbSat=%0d starve=%b",
                     vectors, $time, grant, idx, busy, pre, nb, starve, grant2, idx2, busy2, pre2, nb2, starve2,
                     e.grant, e.idx, e.busy, e.preempt, e.nb, e.nbSat, e.starve);
        end
    endtask

    task automatic applyStimulus(input bit rst, input logic [N-1:0] rq, input logic [N-1:0] dn, input int reps);
        for (int r = 0; r < reps; r++) begin
            @(negedge clk);
            reset = rst;
            req   = rq;
            done  = dn;
            if (rst) modelReset();
            else modelStep(rq, dn);
            expQ.push_back(modelOutputs());
            if (rst) begin
                #1;
                vectors++;
                if (grant !== '0 || busy !== 1'b0 || grant2 !== '0) begin
                    miscompares++;
                    $display("[TB] FAIL asyncReset t=%0t got grant=%b busy=%b grant2=%b, want all zero",
                             $time, grant, busy, grant2);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        logic [N-1:0] rq;
        logic [N-1:0] dn;
        bit           rst;

        applyStimulus(1'b1, 3'b000, 3'b000, 2);

        // Two contending round-robin masters with forced release.
        applyStimulus(1'b0, 3'b110, 3'b000, 6);
        applyStimulus(1'b0, 3'b000, 3'b000, 3);

        // Preemption of master 1, bounded master-0 grant, then master 1 regranted.
        applyStimulus(1'b0, 3'b010, 3'b000, 1);
        applyStimulus(1'b0, 3'b011, 3'b000, 1);
        applyStimulus(1'b0, 3'b010, 3'b000, 4);
        applyStimulus(1'b0, 3'b000, 3'b000, 3);

        // Sole requester gets an idle gap between grants.
        applyStimulus(1'b0, 3'b010, 3'b000, 7);
        applyStimulus(1'b0, 3'b000, 3'b000, 3);

        // Unbounded master-0 grant, released by done, then regranted after one idle cycle.
        applyStimulus(1'b0, 3'b001, 3'b000, 11);
        applyStimulus(1'b0, 3'b001, 3'b001, 1);
        applyStimulus(1'b0, 3'b001, 3'b000, 3);
        applyStimulus(1'b0, 3'b000, 3'b001, 1);
        applyStimulus(1'b0, 3'b000, 3'b000, 2);

        // done of master 2 coinciding with req[0] is a plain release, not a preemption.
        applyStimulus(1'b0, 3'b100, 3'b000, 1);
        applyStimulus(1'b0, 3'b101, 3'b100, 1);
        applyStimulus(1'b0, 3'b000, 3'b001, 1);
        applyStimulus(1'b0, 3'b000, 3'b000, 2);

        // Forced release coinciding with req[0] is also not a preemption.
        applyStimulus(1'b0, 3'b010, 3'b000, 2);
        applyStimulus(1'b0, 3'b011, 3'b000, 1);
        applyStimulus(1'b0, 3'b000, 3'b001, 1);
        applyStimulus(1'b0, 3'b000, 3'b000, 2);

        // Five preemptions push the 2-bit counter into saturation.
        for (int p = 0; p < 5; p++) begin
            applyStimulus(1'b0, 3'b010, 3'b000, 1);
            applyStimulus(1'b0, 3'b011, 3'b000, 1);
            applyStimulus(1'b0, 3'b000, 3'b000, 3);
        end

        // Reset in the middle of a grant, then round-robin restarts at master 1.
        applyStimulus(1'b0, 3'b110, 3'b000, 2);
        applyStimulus(1'b1, 3'b110, 3'b000, 1);
        applyStimulus(1'b0, 3'b110, 3'b000, 4);

        for (int c = 0; c < 1500; c++) begin
            rst   = ($urandom_range(0, 399) == 0);
            rq    = N'($urandom_range(0, 7));
            rq[0] = ($urandom_range(0, 3) == 0);
            dn    = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 7)) : '0;
            applyStimulus(rst, rq, dn, 1);
        end

        for (int w = 0; w < 4 && expQ.size() > 0; w++) @(posedge clk);
        #2;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drainTimeout got %0d pending, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
